// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU data port
// and an external host port (loader/debugger).
//
// The CPU owns the memory by default. A pending host access is slotted into
// the first CPU-idle cycle. If the CPU stays busy for MAX_WAIT cycles, the
// arbiter raises cpu_stall for one cycle and serves the host in that cycle.
// Memory read data is combinational and passes straight through to cpu_din.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cpu_addr/oe/we/dout   CPU data port (we: 11 word, 01 [15:8], 10 [7:0])
//   cpu_din               read data to CPU (= m_rdata)
//   cpu_stall             registered; CPU freezes while high
//   host_req/addr/we/wdata host request, held until host_ack (we 00 = read)
//   host_rdata, host_ack  registered read data / one-cycle completion pulse
//   m_addr/oe/we/wdata    memory request
//   m_rdata               combinational memory read data
//   stat_grants/stalls    host-ack and forced-stall counters
//
// Optional feature macro: DMEM_ARB_STATS_EN. When undefined the stat ports
// exist but are tied to zero.

module dmem_arbiter #(
  parameter int MAX_WAIT = 8  // 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_oe,
  input  logic [1:0]  cpu_we,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic [15:0] host_addr,
  input  logic [1:0]  host_we,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_ack,
  output logic [15:0] m_addr,
  output logic        m_oe,
  output logic [1:0]  m_we,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic [15:0] stat_grants,
  output logic [15:0] stat_stalls
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, STALL, ACK} state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       cpu_busy;
  logic       host_grant;

  assign cpu_busy   = cpu_oe | (cpu_we != 2'b00);
  // In STALL the host owns memory no matter what the (frozen) CPU drives.
  assign host_grant = (((state == IDLE) || (state == WAIT)) && host_req && !cpu_busy)
                      || (state == STALL);

  // State register and registered outputs. cpu_stall/host_ack are derived
  // from the next state so they are high exactly in the STALL/ACK cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      cpu_stall  <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= 16'd0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      cpu_stall <= (state_nxt == STALL);
      host_ack  <= (state_nxt == ACK);
      if (host_grant && (host_we == 2'b00))
        host_rdata <= m_rdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        wait_cnt_nxt = 8'd0;
        if (host_req) begin
          if (!cpu_busy) begin
            state_nxt = ACK;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 8'd1;
          end
        end
      end
      WAIT: begin
        if (!host_req) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 8'd0;
        end else if (!cpu_busy) begin
          state_nxt    = ACK;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt >= MAX_W) begin
          state_nxt    = STALL;
          wait_cnt_nxt = 8'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      STALL: state_nxt = ACK;
      ACK:   state_nxt = IDLE;
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Output logic: memory mux. cpu_we is never forwarded during a host grant.
  always_comb begin
    m_addr  = cpu_addr;
    m_oe    = cpu_oe;
    m_we    = cpu_we;
    m_wdata = cpu_dout;
    if (host_grant) begin
      m_addr  = host_addr;
      m_oe    = (host_we == 2'b00);
      m_we    = host_we;
      m_wdata = host_wdata;
    end
  end

  assign cpu_din = m_rdata;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants <= 16'd0;
      stat_stalls <= 16'd0;
    end else begin
      if ((state_nxt == ACK) && (stat_grants != 16'hFFFF))
        stat_grants <= stat_grants + 16'd1;
      // STALL is only entered from WAIT, so each STALL cycle is one entry.
      if ((state_nxt == STALL) && (stat_stalls != 16'hFFFF))
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`else
  assign stat_grants = 16'd0;
  assign stat_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, cpu_dout, cpu_din;
  logic        cpu_oe, cpu_stall;
  logic [1:0]  cpu_we;
  logic        host_req, host_ack;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic [1:0]  host_we;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        m_oe;
  logic [1:0]  m_we;
  logic [15:0] stat_grants, stat_stalls;

  int n_chk = 0;
  int n_fail = 0;
  int exp_grants = 0;
  int exp_stalls = 0;
  logic [15:0] exp_rd = 16'd0;
  logic [15:0] ref_mem [256];
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .m_addr(m_addr), .m_oe(m_oe), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stat_grants(stat_grants), .stat_stalls(stat_stalls)
  );

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  function automatic int idx(logic [15:0] a);
    return int'(a[8:1]);
  endfunction

  // byte-enable merge: we[0] -> [15:8], we[1] -> [7:0]
  function automatic logic [15:0] bw(logic [15:0] o, logic [1:0] we, logic [15:0] d);
    logic [15:0] r;
    r = o;
    if (we[0]) r[15:8] = d[15:8];
    if (we[1]) r[7:0]  = d[7:0];
    return r;
  endfunction

  // memory behind the arbiter
  assign m_rdata = mem[m_addr[8:1]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      mem[m_addr[8:1]] <= bw(mem[m_addr[8:1]], m_we, m_wdata);
    end
  end

  task automatic ref_init();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic drive_cpu(input bit busy, input int kind);
    cpu_addr = 16'($urandom);
    cpu_dout = 16'($urandom);
    cpu_oe   = 1'b0;
    cpu_we   = 2'b00;
    if (busy) begin
      case (kind)
        1: cpu_oe = 1'b1;
        2: begin cpu_we = 2'b11; cpu_addr = host_addr; end
        default: begin
          cpu_we = 2'($urandom);
          cpu_oe = (cpu_we == 2'b00) ? 1'b1 : 1'($urandom);
        end
      endcase
    end
  endtask

  // One host transaction. The CPU is busy for the first L cycles (k=0 is the
  // first cycle host_req is sampled). Grant lands on the first idle cycle if
  // within MW, otherwise on the forced-stall cycle MW+1; ack one cycle later.
  task automatic run_txn(input logic [15:0] ha, input logic [1:0] hwe,
                         input logic [15:0] hwd, input int L, input int kind);
    int g;
    bit stl;
    g   = (L <= MW) ? L : MW + 1;
    stl = (L > MW);
    host_req = 1'b1; host_addr = ha; host_we = hwe; host_wdata = hwd;
    for (int k = 0; k <= g + 1; k++) begin
      drive_cpu(k < L, kind);
      @(negedge clk);
      if (k == g) begin
        if (hwe == 2'b00) exp_rd = ref_mem[idx(ha)];
        n_chk++;
        if (m_addr !== ha || m_we !== hwe || m_oe !== (hwe == 2'b00) ||
            (hwe != 2'b00 && m_wdata !== hwd)) begin
          n_fail++;
          $display("FAIL grant_mux k=%0d: got addr=%h we=%b oe=%b wd=%h want addr=%h we=%b wd=%h",
                   k, m_addr, m_we, m_oe, m_wdata, ha, hwe, hwd);
        end
        n_chk++;
        if (cpu_stall !== stl || host_ack !== 1'b0) begin
          n_fail++;
          $display("FAIL grant_flags k=%0d: got stall=%b ack=%b want stall=%b ack=0",
                   k, cpu_stall, host_ack, stl);
        end
      end else begin
        n_chk++;
        if (m_addr !== cpu_addr || m_we !== cpu_we || m_oe !== cpu_oe || m_wdata !== cpu_dout) begin
          n_fail++;
          $display("FAIL cpu_mux k=%0d: got addr=%h we=%b oe=%b want addr=%h we=%b oe=%b",
                   k, m_addr, m_we, m_oe, cpu_addr, cpu_we, cpu_oe);
        end
        n_chk++;
        if (host_ack !== (k == g + 1) || cpu_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL txn_flags k=%0d g=%0d: got ack=%b stall=%b want ack=%b stall=0",
                   k, g, host_ack, cpu_stall, (k == g + 1));
        end
        if (k == g + 1) begin
          n_chk++;
          if (host_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL host_rdata: got %h want %h", host_rdata, exp_rd);
          end
        end
        if (cpu_oe) begin
          n_chk++;
          if (cpu_din !== ref_mem[idx(cpu_addr)]) begin
            n_fail++;
            $display("FAIL cpu_din addr=%h: got %h want %h", cpu_addr, cpu_din, ref_mem[idx(cpu_addr)]);
          end
        end
      end
      @(posedge clk); #1;
      if (k == g) ref_mem[idx(ha)] = bw(ref_mem[idx(ha)], hwe, hwd);
      else        ref_mem[idx(cpu_addr)] = bw(ref_mem[idx(cpu_addr)], cpu_we, cpu_dout);
    end
    host_req = 1'b0;
    exp_grants++;
    if (stl) exp_stalls++;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      host_req = 1'b0;
      drive_cpu(1'($urandom), 0);
      @(negedge clk);
      n_chk++;
      if (m_addr !== cpu_addr || m_we !== cpu_we || m_oe !== cpu_oe ||
          host_ack !== 1'b0 || cpu_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL idle: got addr=%h we=%b ack=%b stall=%b want addr=%h we=%b ack=0 stall=0",
                 m_addr, m_we, host_ack, cpu_stall, cpu_addr, cpu_we);
      end
      if (cpu_oe) begin
        n_chk++;
        if (cpu_din !== ref_mem[idx(cpu_addr)]) begin
          n_fail++;
          $display("FAIL idle_cpu_din: got %h want %h", cpu_din, ref_mem[idx(cpu_addr)]);
        end
      end
      @(posedge clk); #1;
      ref_mem[idx(cpu_addr)] = bw(ref_mem[idx(cpu_addr)], cpu_we, cpu_dout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; host_req = 1'b1; host_addr = 16'h1111; host_we = 2'b00; host_wdata = 16'h0;
    drive_cpu(1'b1, 1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if (host_ack !== 1'b0 || cpu_stall !== 1'b0 || host_rdata !== 16'h0 ||
        stat_grants !== 16'h0 || stat_stalls !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got ack=%b stall=%b rdata=%h sg=%h ss=%h want all 0",
               host_ack, cpu_stall, host_rdata, stat_grants, stat_stalls);
    end
    @(posedge clk); #1;
    rst = 1'b0; host_req = 1'b0;
    ref_init(); exp_rd = 16'h0; exp_grants = 0; exp_stalls = 0;
    idle_cycles(2);
  endtask

  task automatic test_idle_host();
    run_txn(16'h0040, 2'b11, 16'hBEEF, 0, 0);
    idle_cycles(1);
    run_txn(16'h0040, 2'b00, 16'h0000, 0, 0);
    n_chk++;
    if (host_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL read_beef: got %h want beef", host_rdata);
    end
    run_txn(16'h0010, 2'b11, 16'h1234, 0, 0);
    host_req = 1'b0; cpu_oe = 1'b1; cpu_we = 2'b00; cpu_addr = 16'h0010;
    @(negedge clk);
    n_chk++;
    if (cpu_din !== 16'h1234) begin
      n_fail++;
      $display("FAIL cpu_lw_after_host_write: got %h want 1234", cpu_din);
    end
    @(posedge clk); #1;
    // host write must leave host_rdata untouched
    n_chk++;
    if (host_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rdata_kept_on_write: got %h want beef", host_rdata);
    end
  endtask

  task automatic test_wait_paths();
    run_txn(16'h0080, 2'b00, 16'h0, 2, 0);      // busy 2, then grant, no stall
    run_txn(16'h00A2, 2'b00, 16'h0, MW, 1);     // grant on last wait cycle
    run_txn(16'h00C4, 2'b00, 16'h0, 20, 1);     // cpu_oe held: forced stall
    run_txn(16'h0030, 2'b11, 16'hA5C3, MW + 2, 2); // cpu word write during stall
    idle_cycles(1);
    cpu_oe = 1'b1; cpu_we = 2'b00; cpu_addr = 16'h0030;
    @(negedge clk);
    n_chk++;
    if (cpu_din !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL stall_host_wins: got %h want a5c3", cpu_din);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    host_req = 1'b1; host_addr = 16'h0020; host_we = 2'b11; host_wdata = 16'hDEAD;
    for (int k = 0; k < MW + 4; k++) begin
      host_req = (k < 2);
      cpu_oe = 1'b1; cpu_we = 2'b00; cpu_addr = 16'h0020; cpu_dout = 16'h0;
      @(negedge clk);
      n_chk++;
      if (m_we !== 2'b00 || m_addr !== 16'h0020 || host_ack !== 1'b0 ||
          cpu_stall !== 1'b0 || cpu_din !== ref_mem[idx(16'h0020)]) begin
        n_fail++;
        $display("FAIL abort k=%0d: got we=%b ack=%b stall=%b din=%h want we=00 ack=0 stall=0 din=%h",
                 k, m_we, host_ack, cpu_stall, cpu_din, ref_mem[idx(16'h0020)]);
      end
      @(posedge clk); #1;
    end
    run_txn(16'h0022, 2'b00, 16'h0, 0, 0);
  endtask

  task automatic test_reset_in_wait();
    host_req = 1'b1; host_addr = 16'h0044; host_we = 2'b00;
    for (int k = 0; k < 3; k++) begin
      drive_cpu(1'b1, 1);
      rst = (k == 2);
      @(posedge clk); #1;
    end
    rst = 1'b0; host_req = 1'b0;
    drive_cpu(1'b0, 0);
    @(negedge clk);
    n_chk++;
    if (host_ack !== 1'b0 || cpu_stall !== 1'b0 || host_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_in_wait: got ack=%b stall=%b rdata=%h want 0 0 0",
               host_ack, cpu_stall, host_rdata);
    end
    @(posedge clk); #1;
    ref_init(); exp_rd = 16'h0; exp_grants = 0; exp_stalls = 0;
    run_txn(16'h0046, 2'b00, 16'h0, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      idle_cycles($urandom_range(0, 2));
      run_txn({7'($urandom), 8'($urandom_range(0, 15)), 1'b0}, 2'($urandom),
              16'($urandom), $urandom_range(0, MW + 3), 0);
    end
    idle_cycles(1);
  endtask

  task automatic test_stats();
    logic [15:0] wg, ws;
`ifdef DMEM_ARB_STATS_EN
    wg = 16'(exp_grants); ws = 16'(exp_stalls);
`else
    wg = 16'h0; ws = 16'h0;
`endif
    @(negedge clk);
    n_chk++;
    if (stat_grants !== wg || stat_stalls !== ws) begin
      n_fail++;
      $display("FAIL stats: got grants=%0d stalls=%0d want %0d %0d", stat_grants, stat_stalls, wg, ws);
    end
  endtask

  initial begin
    test_reset();
    test_idle_host();
    test_wait_paths();
    test_abort();
    test_stats();
    test_reset_in_wait();
    test_random();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
